// File: rtl/esteira_pkg.sv
// Shared types for the wine-conveyor sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package esteira_pkg;

    localparam int LARG_ESTADO = 3;

    typedef enum logic [LARG_ESTADO-1:0] {
        OCIOSO       = 3'd0,
        MOVER        = 3'd1,
        OPERAR       = 3'd2,
        ESPERA_ROLHA = 3'd3,
        DESCARTAR    = 3'd4,
        FALHA_ST     = 3'd5
    } estado_t;

endpackage

// File: rtl/contador_estoque_rolhas.sv
// Cork-stock counter: saturating at MAX on refill, never below zero on consume.
// Latency: dec/add sampled at edge N, new stock visible from N+1.
// Backpressure: none; disponivel tells the sequencer whether a cork can be taken.
// Ports: clk, rst_n (async active-low), dec (consume one), add (refill by qtd),
//        qtd (refill amount), estoque (current stock), disponivel (stock > 0).
module contador_estoque_rolhas #(
    parameter int LARG = 5,
    parameter int MAX  = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dec,
    input  logic            add,
    input  logic [LARG-1:0] qtd,
    output logic [LARG-1:0] estoque,
    output logic            disponivel
);

    logic [LARG-1:0] estoque_q, estoque_d;
    logic [LARG:0]   soma;

    // One extra bit so stock + refill cannot wrap before the clamp.
    always_comb begin
        soma = {1'b0, estoque_q};
        if (add) begin
            soma = soma + {1'b0, qtd};
        end
        if (dec && (soma != '0)) begin
            soma = soma - (LARG+1)'(1);
        end
        if (soma > (LARG+1)'(MAX)) begin
            soma = (LARG+1)'(MAX);
        end
        estoque_d = soma[LARG-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estoque_q <= LARG'(MAX);
        end else begin
            estoque_q <= estoque_d;
        end
    end

    assign estoque    = estoque_q;
    assign disponivel = (estoque_q != '0);

endmodule

// File: rtl/esteira_vinho_param.sv
// Conveyor sequencer: moves a bottle through NUM_ESTACOES stations with req/ack per station,
// Latency: START->MOTOR 1 cycle; sensor->OP_REQ 2 cycles; ack->OP_REQ drop 1 cycle; all outputs registered.
// Backpressure: OP_REQ held until OP_ACK; cork station stalls in ESPERA_ROLHA until stock > 0.
// Ports: CLK, RESET (async active-low), START, ADD_ROLHA, SENSOR_POS, OP_ACK, QUALIDADE_OK in;
//        MOTOR, OP_REQ, ALARME_ROLHA, DESCARTE, FALHA, ESTOQUE, GARRAFAS, LOTES, ESTADO, ESTACAO out.
// Build option: define ESTEIRA_TIMEOUT_EN to enable the motor-run timeout and the sticky FALHA_ST state.
module esteira_vinho_param
    import esteira_pkg::*;
#(
    parameter int NUM_ESTACOES   = 4,
    parameter int EST_ROLHA      = 1,
    parameter int EST_CQ         = 2,
    parameter int LARG_ESTOQUE   = 5,
    parameter int ESTOQUE_MAX    = 20,
    parameter int QTD_RECARGA    = 5,
    parameter int TAM_LOTE       = 12,
    parameter int LARG_LOTES     = 4,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        START,
    input  logic                        ADD_ROLHA,
    input  logic [NUM_ESTACOES-1:0]     SENSOR_POS,
    input  logic [NUM_ESTACOES-1:0]     OP_ACK,
    input  logic                        QUALIDADE_OK,
    output logic                        MOTOR,
    output logic [NUM_ESTACOES-1:0]     OP_REQ,
    output logic                        ALARME_ROLHA,
    output logic                        DESCARTE,
    output logic                        FALHA,
    output logic [LARG_ESTOQUE-1:0]     ESTOQUE,
    output logic [$clog2(TAM_LOTE)-1:0] GARRAFAS,
    output logic [LARG_LOTES-1:0]       LOTES,
    output logic [LARG_ESTADO-1:0]      ESTADO,
    output logic [$clog2(NUM_ESTACOES)-1:0] ESTACAO
);

    localparam int LE = $clog2(NUM_ESTACOES);
    localparam int LG = $clog2(TAM_LOTE);
    localparam logic [LE-1:0] IDX_ROLHA   = LE'(EST_ROLHA);
    localparam logic [LE-1:0] IDX_CQ      = LE'(EST_CQ);
    localparam logic [LE-1:0] IDX_ULT     = LE'(NUM_ESTACOES-1);
    localparam logic [LG-1:0] GARRAFA_ULT = LG'(TAM_LOTE-1);

    estado_t                 estado_q, estado_d;
    logic [LE-1:0]           estacao_q, estacao_d;
    logic [LG-1:0]           garrafas_q, garrafas_d;
    logic [LARG_LOTES-1:0]   lotes_q, lotes_d;
    logic [NUM_ESTACOES-1:0] op_req_q, op_req_d;
    logic                    motor_q, motor_d;
    logic                    alarme_q, alarme_d;
    logic                    descarte_q, descarte_d;
    logic                    dec_rolha;
    logic                    disponivel;

`ifdef ESTEIRA_TIMEOUT_EN
    localparam int LT = $clog2(TIMEOUT_CICLOS + 1);
    logic [LT-1:0] tmo_q, tmo_d;
    logic          falha_q, falha_d;
`endif

    contador_estoque_rolhas #(
        .LARG (LARG_ESTOQUE),
        .MAX  (ESTOQUE_MAX)
    ) u_estoque (
        .clk        (CLK),
        .rst_n      (RESET),
        .dec        (dec_rolha),
        .add        (ADD_ROLHA),
        .qtd        (LARG_ESTOQUE'(QTD_RECARGA)),
        .estoque    (ESTOQUE),
        .disponivel (disponivel)
    );

    always_comb begin
        estado_d   = estado_q;
        estacao_d  = estacao_q;
        garrafas_d = garrafas_q;
        lotes_d    = lotes_q;
        op_req_d   = '0;
        dec_rolha  = 1'b0;
`ifdef ESTEIRA_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (estado_q)
            OCIOSO: begin
                if (START) begin
                    estacao_d = '0;
                    estado_d  = MOVER;
`ifdef ESTEIRA_TIMEOUT_EN
                    tmo_d     = '0;
`endif
                end
            end
            MOVER: begin
                if (SENSOR_POS[estacao_q]) begin
                    estado_d = OPERAR;
`ifdef ESTEIRA_TIMEOUT_EN
                end else if (tmo_q == LT'(TIMEOUT_CICLOS - 1)) begin
                    estado_d = FALHA_ST;
                end else begin
                    tmo_d = tmo_q + LT'(1);
`endif
                end
            end
            OPERAR: begin
                // First OPERAR cycle decides between raising the request and
                // stalling for corks; afterwards the request is held until ack.
                if (op_req_q[estacao_q]) begin
                    if (OP_ACK[estacao_q]) begin
                        dec_rolha = (estacao_q == IDX_ROLHA);
                        if ((estacao_q == IDX_CQ) && !QUALIDADE_OK) begin
                            estado_d = DESCARTAR;
                        end else if (estacao_q == IDX_ULT) begin
                            estado_d = OCIOSO;
                            if (garrafas_q == GARRAFA_ULT) begin
                                garrafas_d = '0;
                                if (lotes_q != '1) begin
                                    lotes_d = lotes_q + LARG_LOTES'(1);
                                end
                            end else begin
                                garrafas_d = garrafas_q + LG'(1);
                            end
                        end else begin
                            estacao_d = estacao_q + LE'(1);
                            estado_d  = MOVER;
`ifdef ESTEIRA_TIMEOUT_EN
                            tmo_d     = '0;
`endif
                        end
                    end else begin
                        op_req_d = op_req_q;
                    end
                end else if ((estacao_q == IDX_ROLHA) && !disponivel) begin
                    estado_d = ESPERA_ROLHA;
                end else begin
                    op_req_d[estacao_q] = 1'b1;
                end
            end
            ESPERA_ROLHA: begin
                if (disponivel) begin
                    estado_d = OPERAR;
                end
            end
            DESCARTAR: estado_d = OCIOSO;
            FALHA_ST:  estado_d = FALHA_ST;
            default:   estado_d = OCIOSO;
        endcase

        // Level outputs are decoded from the next state so they are registered
        // alongside it and change on the same edge as ESTADO.
        motor_d    = (estado_d == MOVER);
        alarme_d   = (estado_d == ESPERA_ROLHA);
        descarte_d = (estado_d == DESCARTAR);
`ifdef ESTEIRA_TIMEOUT_EN
        falha_d    = (estado_d == FALHA_ST);
`endif
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            estado_q   <= OCIOSO;
            estacao_q  <= '0;
            garrafas_q <= '0;
            lotes_q    <= '0;
            op_req_q   <= '0;
            motor_q    <= 1'b0;
            alarme_q   <= 1'b0;
            descarte_q <= 1'b0;
`ifdef ESTEIRA_TIMEOUT_EN
            tmo_q      <= '0;
            falha_q    <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            estacao_q  <= estacao_d;
            garrafas_q <= garrafas_d;
            lotes_q    <= lotes_d;
            op_req_q   <= op_req_d;
            motor_q    <= motor_d;
            alarme_q   <= alarme_d;
            descarte_q <= descarte_d;
`ifdef ESTEIRA_TIMEOUT_EN
            tmo_q      <= tmo_d;
            falha_q    <= falha_d;
`endif
        end
    end

    assign MOTOR        = motor_q;
    assign OP_REQ       = op_req_q;
    assign ALARME_ROLHA = alarme_q;
    assign DESCARTE     = descarte_q;
    assign GARRAFAS     = garrafas_q;
    assign LOTES        = lotes_q;
    assign ESTADO       = estado_q;
    assign ESTACAO      = estacao_q;
`ifdef ESTEIRA_TIMEOUT_EN
    assign FALHA        = falha_q;
`else
    assign FALHA        = 1'b0;
`endif

endmodule

// File: tb/tb_esteira_vinho_param.sv
// Bench for the conveyor sequencer: randomized station timing and noise, scoreboard of expected events.
// Latency: events checked at the falling edge after the DUT presents them.
// Backpressure: the driver answers OP_REQ with OP_ACK after a random delay.
module tb_esteira_vinho_param;

    localparam int NE   = 4;
    localparam int MAXE = 20;
    localparam int REC  = 5;
    localparam int LOTE = 12;

    localparam int EV_REQ   = 0;
    localparam int EV_ALARM = 1;
    localparam int EV_DISC  = 2;
    localparam int EV_DONE  = 3;

    typedef struct {
        int kind;
        int st;
        int a;
        int b;
        int c;
    } ev_t;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          START;
    logic          ADD_ROLHA;
    logic [NE-1:0] SENSOR_POS;
    logic [NE-1:0] OP_ACK;
    logic          QUALIDADE_OK;
    logic          MOTOR;
    logic [NE-1:0] OP_REQ;
    logic          ALARME_ROLHA;
    logic          DESCARTE;
    logic          FALHA;
    logic [4:0]    ESTOQUE;
    logic [3:0]    GARRAFAS;
    logic [3:0]    LOTES;
    logic [2:0]    ESTADO;
    logic [1:0]    ESTACAO;

    esteira_vinho_param #(
        .NUM_ESTACOES   (NE),
        .EST_ROLHA      (1),
        .EST_CQ         (2),
        .LARG_ESTOQUE   (5),
        .ESTOQUE_MAX    (MAXE),
        .QTD_RECARGA    (REC),
        .TAM_LOTE       (LOTE),
        .LARG_LOTES     (4),
        .TIMEOUT_CICLOS (8)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .START        (START),
        .ADD_ROLHA    (ADD_ROLHA),
        .SENSOR_POS   (SENSOR_POS),
        .OP_ACK       (OP_ACK),
        .QUALIDADE_OK (QUALIDADE_OK),
        .MOTOR        (MOTOR),
        .OP_REQ       (OP_REQ),
        .ALARME_ROLHA (ALARME_ROLHA),
        .DESCARTE     (DESCARTE),
        .FALHA        (FALHA),
        .ESTOQUE      (ESTOQUE),
        .GARRAFAS     (GARRAFAS),
        .LOTES        (LOTES),
        .ESTADO       (ESTADO),
        .ESTACAO      (ESTACAO)
    );

    always #5 CLK = ~CLK;

    int  n_cmp = 0;
    int  n_err = 0;
    ev_t sb[$];
    bit  mon_en = 1'b0;

    // Reference model: bottle-level bookkeeping of stock and counters.
    int m_stock, m_garr, m_lotes;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int other(input int s);
        return (s + 1 + int'($urandom_range(0, NE-2))) % NE;
    endfunction

    task automatic chk(input string nome, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input int st, input int a, input int b, input int c);
        ev_t e;
        e.kind = k; e.st = st; e.a = a; e.b = b; e.c = c;
        sb.push_back(e);
    endtask

    task automatic pop(input string nome, output ev_t e);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: DUT event with empty scoreboard (t=%0t)", nome, $time);
            e.kind = -1; e.st = -1; e.a = -1; e.b = -1; e.c = -1;
        end else begin
            e = sb.pop_front();
        end
    endtask

    // Monitor: pops expected events whenever the DUT presents one.
    logic [2:0]    p_estado = '0;
    logic [NE-1:0] p_req    = '0;
    logic          p_alarme = 1'b0;
    logic          p_desc   = 1'b0;

    always @(negedge CLK) begin
        ev_t e;
        if (mon_en) begin
            if (ALARME_ROLHA && !p_alarme) begin
                pop("alarm_evt", e);
                chk("alarm_kind", e.kind, EV_ALARM);
                chk("alarm_opreq", int'(OP_REQ), 0);
                chk("alarm_stock", int'(ESTOQUE), 0);
            end
            if ((OP_REQ != '0) && (p_req == '0)) begin
                pop("req_evt", e);
                chk("req_kind", e.kind, EV_REQ);
                chk("req_vec", int'(OP_REQ), 1 << e.st);
                chk("req_stock", int'(ESTOQUE), e.a);
            end
            if (DESCARTE) begin
                pop("disc_evt", e);
                chk("disc_kind", e.kind, EV_DISC);
                chk("disc_garrafas", int'(GARRAFAS), e.a);
                chk("disc_single_cycle", int'(p_desc), 0);
            end
            if ((p_estado == 3'd2) && (ESTADO == 3'd0)) begin
                pop("done_evt", e);
                chk("done_kind", e.kind, EV_DONE);
                chk("done_garrafas", int'(GARRAFAS), e.a);
                chk("done_lotes", int'(LOTES), e.b);
                chk("done_stock", int'(ESTOQUE), e.c);
            end
            chk("opreq_onehot0", int'($onehot0(OP_REQ)), 1);
`ifndef ESTEIRA_TIMEOUT_EN
            chk("falha_tied_low", int'(FALHA), 0);
`endif
        end
        p_estado = ESTADO;
        p_req    = OP_REQ;
        p_alarme = ALARME_ROLHA;
        p_desc   = DESCARTE;
    end

    // Drives one bottle; abort_st >= 0 stops once that station's request is seen.
    task automatic run_bottle(input bit ok, input bit add1, input int abort_st);
        int  w;
        int  lat;
        bit  added;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("motor_after_start", int'(MOTOR), 1);
        for (int s = 0; s < NE; s++) begin
            w = $urandom_range(0, 3);
            repeat (w) begin
                SENSOR_POS = $urandom_range(0, 1) ? NE'(1 << other(s)) : '0;
                OP_ACK     = $urandom_range(0, 1) ? NE'(1 << other(s)) : '0;
                START      = 1'($urandom_range(0, 1));
                @(negedge CLK);
            end
            added = 1'b0;
            if (s == 1 && m_stock == 0) begin
                push(EV_ALARM, s, 0, 0, 0);
                m_stock = imin(m_stock + REC, MAXE);
            end
            push(EV_REQ, s, m_stock, 0, 0);
            SENSOR_POS = NE'(1 << s);
            OP_ACK     = '0;
            START      = 1'b0;
            @(negedge CLK);
            SENSOR_POS = '0;
            chk("motor_off_at_sensor", int'(MOTOR), 0);
            chk("state_operar", int'(ESTADO), 2);
            w = 0;
            while (!OP_REQ[s] && w < 20) begin
                if (ALARME_ROLHA && !added) begin
                    added     = 1'b1;
                    ADD_ROLHA = 1'b1;
                    @(negedge CLK);
                    ADD_ROLHA = 1'b0;
                    chk("stock_after_refill", int'(ESTOQUE), m_stock);
                    lat = 0;
                    while (!OP_REQ[s] && lat < 10) begin
                        @(negedge CLK);
                        lat++;
                    end
                    chk("refill_to_req_cycles", lat, 2);
                end else begin
                    @(negedge CLK);
                    w++;
                end
            end
            chk("req_seen", int'(OP_REQ[s]), 1);
            if (!OP_REQ[s] || s == abort_st) return;
            w = $urandom_range(0, 3);
            repeat (w) begin
                OP_ACK = $urandom_range(0, 1) ? NE'(1 << other(s)) : '0;
                START  = 1'($urandom_range(0, 1));
                QUALIDADE_OK = 1'($urandom_range(0, 1));
                @(negedge CLK);
            end
            if (s == 1) m_stock = imin(m_stock - 1 + (add1 ? REC : 0), MAXE);
            if (s == 2 && !ok) begin
                push(EV_DISC, s, m_garr, 0, 0);
            end else if (s == NE-1) begin
                m_garr++;
                if (m_garr == LOTE) begin
                    m_garr  = 0;
                    m_lotes = imin(m_lotes + 1, 15);
                end
                push(EV_DONE, s, m_garr, m_lotes, m_stock);
            end
            OP_ACK       = NE'(1 << s);
            QUALIDADE_OK = (s == 2) ? ok : 1'($urandom_range(0, 1));
            ADD_ROLHA    = (s == 1) && add1;
            START        = 1'b0;
            @(negedge CLK);
            OP_ACK       = '0;
            ADD_ROLHA    = 1'b0;
            QUALIDADE_OK = 1'b0;
            chk("req_drop_after_ack", int'(OP_REQ), 0);
            if (s == 2 && !ok) begin
                @(negedge CLK);
                chk("descarte_cleared", int'(DESCARTE), 0);
                chk("idle_after_discard", int'(ESTADO), 0);
                return;
            end
            if (s == NE-1) begin
                chk("idle_after_last", int'(ESTADO), 0);
                return;
            end
            chk("motor_next_station", int'(MOTOR), 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        RESET = 1'b0; START = 1'b0; ADD_ROLHA = 1'b0;
        SENSOR_POS = '0; OP_ACK = '0; QUALIDADE_OK = 1'b0;
        m_stock = MAXE; m_garr = 0; m_lotes = 0;
        repeat (2) @(negedge CLK);
        chk("rst_estado", int'(ESTADO), 0);
        chk("rst_estoque", int'(ESTOQUE), MAXE);
        chk("rst_motor", int'(MOTOR), 0);
        chk("rst_opreq", int'(OP_REQ), 0);
        chk("rst_garrafas", int'(GARRAFAS), 0);
        chk("rst_lotes", int'(LOTES), 0);
        chk("rst_alarme", int'(ALARME_ROLHA), 0);
        chk("rst_descarte", int'(DESCARTE), 0);
        chk("rst_falha", int'(FALHA), 0);
        chk("rst_estacao", int'(ESTACAO), 0);
        RESET = 1'b1;
        @(negedge CLK);
        mon_en = 1'b1;

        run_bottle(1'b1, 1'b0, -1);
        run_bottle(1'b0, 1'b0, -1);
        // Enough bottles to drain the stock and wrap the lot counter twice.
        for (int i = 0; i < 30; i++) begin
            run_bottle((i % 7) != 3, 1'b0, -1);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        // Asynchronous reset while station 2 is being requested.
        run_bottle(1'b1, 1'b0, 2);
        #2;
        mon_en = 1'b0;
        chk("sb_drained_before_reset", sb.size(), 0);
        chk("opreq2_before_reset", int'(OP_REQ), 4);
        RESET = 1'b0;
        #1;
        chk("arst_estado", int'(ESTADO), 0);
        chk("arst_opreq", int'(OP_REQ), 0);
        chk("arst_motor", int'(MOTOR), 0);
        chk("arst_estoque", int'(ESTOQUE), MAXE);
        chk("arst_garrafas", int'(GARRAFAS), 0);
        chk("arst_lotes", int'(LOTES), 0);
        sb.delete();
        m_stock = MAXE; m_garr = 0; m_lotes = 0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        mon_en = 1'b1;

        // Stock 19 then refill coinciding with the cork-station ack saturates at 20.
        run_bottle(1'b1, 1'b0, -1);
        run_bottle(1'b1, 1'b1, -1);
        repeat (3) @(negedge CLK);
        chk("sb_empty_end", sb.size(), 0);

`ifdef ESTEIRA_TIMEOUT_EN
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cnt = 0;
        while (MOTOR && cnt < 50) begin
            cnt++;
            @(negedge CLK);
        end
        chk("timeout_mover_cycles", cnt, 8);
        chk("timeout_falha", int'(FALHA), 1);
        chk("timeout_estado", int'(ESTADO), 5);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        chk("falha_sticky_estado", int'(ESTADO), 5);
        chk("falha_sticky_motor", int'(MOTOR), 0);
`else
        cnt = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/esteira_vinho_param.md
# esteira_vinho_param

Parametrised successor of the wine-conveyor automation: one sequencer drives the conveyor through `NUM_ESTACOES` stations, each with a position sensor and a request/acknowledge operation handshake. It owns the cork stock and the bottle/lot counters. It adds a configurable quality-control station, discard handling and a motor-timeout fault. It sits between the board I/O (debounced keys and sensors) and the display/BCD logic.

## Interface
- `NUM_ESTACOES`, 4: number of stations, ≥2; station `NUM_ESTACOES-1` is the last station.
- `EST_ROLHA`, 1: index of the station that consumes one cork.
- `EST_CQ`, 2: index of the quality-control station.
- `LARG_ESTOQUE`, 5: width of the cork-stock counter.
- `ESTOQUE_MAX`, 20: cork-stock saturation value.
- `QTD_RECARGA`, 5: corks added per `ADD_ROLHA` pulse.
- `TAM_LOTE`, 12: bottles per lot.
- `LARG_LOTES`, 4: width of the lot counter.
- `TIMEOUT_CICLOS`, 1000: maximum motor-run cycles without the target sensor.
- `CLK  in  1`: system clock.
- `RESET  in  1`: asynchronous, active-low reset.
- `START  in  1`: one-cycle pulse that begins a bottle cycle.
- `ADD_ROLHA  in  1`: one-cycle pulse that refills corks.
- `SENSOR_POS  in  NUM_ESTACOES`: per-station bottle-in-position sensors.
- `OP_ACK  in  NUM_ESTACOES`: per-station operation-done pulses.
- `QUALIDADE_OK  in  1`: QC verdict, sampled with `OP_ACK[EST_CQ]`.
- `MOTOR  out  1`: conveyor motor on.
- `OP_REQ  out  NUM_ESTACOES`: per-station operation request, held as a level.
- `ALARME_ROLHA  out  1`: high while waiting for corks.
- `DESCARTE  out  1`: one-cycle discard pulse.
- `FALHA  out  1`: sticky motor-timeout fault.
- `ESTOQUE  out  LARG_ESTOQUE`: current cork stock.
- `GARRAFAS  out  $clog2(TAM_LOTE)`: bottles in the current lot.
- `LOTES  out  LARG_LOTES`: completed lots.
- `ESTADO  out  3`: current FSM state encoding.
- `ESTACAO  out  $clog2(NUM_ESTACOES)`: current station index.

## Operation
- States and encodings: `OCIOSO`=0, `MOVER`=1, `OPERAR`=2, `ESPERA_ROLHA`=3, `DESCARTAR`=4, `FALHA_ST`=5.
- `OCIOSO`:
  - on `START`, set `ESTACAO`=0 and go to `MOVER`.
  - `START` is ignored in every other state.
- `MOVER`:
  - `MOTOR`=1.
  - When `SENSOR_POS[ESTACAO]`=1, go to `OPERAR` and drop `MOTOR` in the same transition.
  - Sensors of other stations are ignored.
- `OPERAR`:
  - If `ESTACAO`==`EST_ROLHA` and `ESTOQUE`==0, go to `ESPERA_ROLHA` without asserting `OP_REQ`.
  - Otherwise hold `OP_REQ[ESTACAO]`=1 until `OP_ACK[ESTACAO]`.
  - An ack at the cork station decrements `ESTOQUE` by 1.
  - An ack at the QC station with `QUALIDADE_OK`=0 goes to `DESCARTAR`.
  - On any other ack: if this is the last station, increment `GARRAFAS` and return to `OCIOSO`; else increment `ESTACAO` and go to `MOVER`.
  - `OP_ACK` on non-current stations is ignored.
- `ESPERA_ROLHA`: `ALARME_ROLHA`=1; once `ESTOQUE`>0, return to `OPERAR`.
- `DESCARTAR`:
  - `DESCARTE`=1 for exactly one cycle, then `OCIOSO`.
  - The bottle is not counted and the remaining stations are skipped.
- `GARRAFAS` counting:
  - `GARRAFAS` counts 0..`TAM_LOTE`-1.
  - The increment that would reach `TAM_LOTE` wraps it to 0 and increments `LOTES` in the same cycle.
  - `LOTES` saturates at all-ones.
- `ADD_ROLHA`:
  - stock = min(stock + `QTD_RECARGA`, `ESTOQUE_MAX`), accepted in every state.
  - Refill and consume in the same cycle: stock = min(stock − 1 + `QTD_RECARGA`, `ESTOQUE_MAX`).
- Reset values:
  - state `OCIOSO`; `ESTACAO`=0.
  - All outputs 0, except `ESTOQUE`=`ESTOQUE_MAX`.
  - `GARRAFAS`=0, `LOTES`=0.
- Reset asserted mid-cycle aborts the bottle immediately; counters return to their reset values.

## Timing
- All outputs are registered.
- `START` sampled at edge N gives `MOTOR`=1 from N+1.
- Sensor sampled at N gives `MOTOR`=0 and the state `OPERAR` from N+1; `OP_REQ` rises at N+2 (or `ALARME_ROLHA`, if the stock is empty).
- `OP_ACK` sampled at N gives `OP_REQ`=0 from N+1; counter and stock updates become visible at N+1.
- `DESCARTE` is high for the single cycle spent in `DESCARTAR`.
- `OP_REQ` is one-hot or zero at all times.

## Configuration
- `ESTEIRA_TIMEOUT_EN` defined:
  - A run counter counts cycles in `MOVER`.
  - Reaching `TIMEOUT_CICLOS` without the sensor moves to `FALHA_ST`: `FALHA`=1, `MOTOR`=0.
  - `FALHA_ST` is left only through `RESET`.
  - The counter clears on every entry to `MOVER`.
- `ESTEIRA_TIMEOUT_EN` undefined: no counter, `FALHA` tied to 0, `FALHA_ST` unreachable; `MOVER` waits indefinitely.

## Structure
- Package `esteira_pkg`: state enum typedef and its encodings, `ESTADO` width constant.
- Sub-module `contador_estoque_rolhas`:
  - Saturating up/down counter with inputs `dec`, `add` and a refill amount.
  - Outputs the stock and a `disponivel` flag.
- The FSM, station index, lot counters and timeout counter stay in the top module.

## Test plan
- Full good cycle, default parameters: `START`, then sensor plus ack at stations 0..3 with `QUALIDADE_OK`=1 -> `GARRAFAS`=1, `ESTOQUE`=19, back to `OCIOSO` (`ESTADO`=0).
- Stock starts at 0 (20 good cycles run first), then a bottle reaches station 1 -> `ALARME_ROLHA`=1 and `OP_REQ[1]`=0; an `ADD_ROLHA` pulse then gives `ESTOQUE`=5, followed by `OP_REQ[1]`=1 two cycles later.
- QC ack with `QUALIDADE_OK`=0 -> one-cycle `DESCARTE`, `GARRAFAS` unchanged, station 3 never requested.
- 12 good cycles -> `GARRAFAS` wraps to 0 and `LOTES`=1 on the same edge; with stock at 19, `ADD_ROLHA` in the same cycle as the station-1 ack -> `ESTOQUE`=20 (saturated).
- With `ESTEIRA_TIMEOUT_EN` and `TIMEOUT_CICLOS`=8, the sensor is never asserted -> `FALHA`=1 and `MOTOR`=0 after 8 `MOVER` cycles; `START` is ignored until `RESET`.
- `RESET` pulled low while `OP_REQ[2]`=1 -> all outputs drop asynchronously, `ESTOQUE`=20, `ESTADO`=0.
